// File: rtl/seq_det_sched.sv
// seq_det_sched: one "00011" Mealy detector shared by NCH byte-wide requesters.
// Define SEQ_DET_SCHED_FIXED_PRIO_EN for a fixed-priority arbiter (lowest channel wins).
module seq_det_sched #(
  parameter int NCH  = 4,
  parameter int W    = 8,
  parameter int CNTW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH*W-1:0]         req_data,
  output logic [NCH-1:0]           req_ready,
  input  logic [NCH-1:0]           ctx_clr,
  output logic                     hit_valid,
  output logic [$clog2(NCH)-1:0]   hit_ch,
  output logic [$clog2(W)-1:0]     hit_pos,
  output logic                     done_valid,
  output logic [$clog2(NCH)-1:0]   done_ch,
  output logic [$clog2(W+1)-1:0]   done_hits,
  output logic                     busy,
  input  logic [$clog2(NCH)-1:0]   rd_ch,
  output logic [CNTW-1:0]          rd_cnt
);

  localparam int CW = $clog2(NCH);
  localparam int PW = $clog2(W);
  localparam int HW = $clog2(W+1);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WB    = 2'd2
  } ctrl_t;

  ctrl_t           state, state_nxt;
  logic [W-1:0]    shreg;
  logic [2:0]      eng, eng_nxt;
  logic            eng_hit;
  logic [CW-1:0]   act;
  logic [PW-1:0]   bidx;
  logic [HW-1:0]   wcnt;
  logic            disc;
  logic [2:0]      ctx [NCH];
  logic [CNTW-1:0] hit_cnt [NCH];
  logic [W-1:0]    words [NCH];
  logic            any_v;
  logic            take;
  logic [CW-1:0]   gnt;

  for (genvar c = 0; c < NCH; c++) begin : g_word
    assign words[c] = req_data[c*W +: W];
  end

  assign any_v = |req_valid;
  assign take  = (state == IDLE) && any_v;

`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    for (int i = NCH-1; i >= 0; i--)
      if (req_valid[CW'(i)]) gnt = CW'(i);
  end
`else
  logic [CW-1:0] ptr;
  logic [CW-1:0] rr_j;
  logic          rr_found;

  // Search starts one past the last winner.
  always_comb begin
    gnt      = '0;
    rr_found = 1'b0;
    rr_j     = '0;
    for (int i = 1; i <= NCH; i++) begin
      rr_j = CW'((int'(ptr) + i) % NCH);
      if (!rr_found && req_valid[rr_j]) begin
        gnt      = rr_j;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= CW'(NCH-1);
    else if (take) ptr <= gnt;
  end
`endif

  assign req_ready = (take && !rst) ? (NCH'(1) << gnt) : '0;
  assign busy      = (state != IDLE);
  assign rd_cnt    = hit_cnt[rd_ch];

  always_comb begin
    eng_nxt = S0;
    eng_hit = 1'b0;
    case (eng)
      S0: eng_nxt = shreg[W-1] ? S0 : S1;
      S1: eng_nxt = shreg[W-1] ? S0 : S2;
      S2: eng_nxt = shreg[W-1] ? S0 : S3;
      S3: eng_nxt = shreg[W-1] ? S4 : S3;
      S4: begin
        eng_nxt = shreg[W-1] ? S0 : S1;
        eng_hit = shreg[W-1];
      end
      default: eng_nxt = S0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_v) state_nxt = SHIFT;
      SHIFT:   if (bidx == PW'(W-1)) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      eng        <= S0;
      act        <= '0;
      bidx       <= '0;
      wcnt       <= '0;
      disc       <= 1'b0;
      hit_valid  <= 1'b0;
      hit_ch     <= '0;
      hit_pos    <= '0;
      done_valid <= 1'b0;
      done_ch    <= '0;
      done_hits  <= '0;
    end else begin
      hit_valid  <= 1'b0;
      done_valid <= 1'b0;
      case (state)
        IDLE: if (any_v) begin
          shreg <= words[gnt];
          eng   <= ctx_clr[gnt] ? S0 : ctx[gnt];
          act   <= gnt;
          bidx  <= '0;
          wcnt  <= '0;
          disc  <= 1'b0;
        end
        SHIFT: begin
          shreg <= shreg << 1;
          eng   <= eng_nxt;
          bidx  <= bidx + 1'b1;
          if (eng_hit) begin
            hit_valid <= 1'b1;
            hit_ch    <= act;
            hit_pos   <= bidx;
            wcnt      <= wcnt + 1'b1;
          end
          if (ctx_clr[act]) disc <= 1'b1;
        end
        WB: begin
          done_valid <= 1'b1;
          done_ch    <= act;
          done_hits  <= wcnt;
          if (ctx_clr[act]) disc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A clear on the active channel discards the rest of that word's side effects.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctx[c]     <= S0;
        hit_cnt[c] <= '0;
      end else if (ctx_clr[c]) begin
        ctx[c]     <= S0;
        hit_cnt[c] <= '0;
      end else begin
        if (state == WB && act == CW'(c) && !disc)
          ctx[c] <= eng;
        if (state == SHIFT && act == CW'(c) && eng_hit && !disc
            && hit_cnt[c] != {CNTW{1'b1}})
          hit_cnt[c] <= hit_cnt[c] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: directed table plus hand sequences for seq_det_sched.
// Expected values are hand-traced through the 00011 detector.
module tb_seq_det_sched;

  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int CNTW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   req_valid;
  logic [NCH*W-1:0] req_data;
  logic [NCH-1:0]   req_ready;
  logic [NCH-1:0]   ctx_clr;
  logic             hit_valid;
  logic [1:0]       hit_ch;
  logic [2:0]       hit_pos;
  logic             done_valid;
  logic [1:0]       done_ch;
  logic [3:0]       done_hits;
  logic             busy;
  logic [1:0]       rd_ch;
  logic [CNTW-1:0]  rd_cnt;

  seq_det_sched #(.NCH(NCH), .W(W), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ctx_clr    (ctx_clr),
    .hit_valid  (hit_valid),
    .hit_ch     (hit_ch),
    .hit_pos    (hit_pos),
    .done_valid (done_valid),
    .done_ch    (done_ch),
    .done_hits  (done_hits),
    .busy       (busy),
    .rd_ch      (rd_ch),
    .rd_cnt     (rd_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int gcyc, hcyc, nhit, hpos, hch, dcyc, dhits, dch;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offer one word on ch and follow it to done_valid (or a bound).
  // clr_cyc / rst_cyc: cycle after grant in which to raise ctx_clr / rst.
  task automatic do_word(input int ch, input logic [W-1:0] d,
                         input int clr_cyc, input int rst_cyc);
    gcyc = -1; hcyc = -1; nhit = 0; hpos = -1; hch = -1;
    dcyc = -1; dhits = -1; dch = -1;
    @(posedge clk); #1;
    req_data[ch*W +: W] = d;
    req_valid[ch] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gcyc < 0 && req_ready[ch]) gcyc = c;
      if (gcyc >= 0 && c > gcyc) begin
        if (hit_valid) begin
          nhit++; hpos = hit_pos; hch = hit_ch; hcyc = c - gcyc;
        end
        if (done_valid) begin
          dcyc = c - gcyc; dhits = done_hits; dch = done_ch;
        end
      end
      if (dcyc >= 0) break;
      @(posedge clk); #1;
      if (gcyc == c) begin
        req_valid[ch] = 1'b0;
        req_data[ch*W +: W] = ~d;
      end
      if (gcyc >= 0) begin
        ctx_clr[ch] = (c - gcyc + 1 == clr_cyc);
        if (c - gcyc + 1 == rst_cyc) begin
          rst = 1'b1;
          break;
        end
      end
    end
    ctx_clr = '0;
    req_valid[ch] = 1'b0;
  endtask

  typedef struct {
    int          ch;
    logic [7:0]  d;
    int          nhit;
    int          pos;
    int          cnt;
  } vec_t;

  vec_t tv [7];
  int   gseq [5];
  int   gt [5];
  int   k, gch, ndone;
  int   exp_g;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{0, 8'h18, 1, 4, 1};
    tv[1] = '{1, 8'hF1, 0, -1, 0};
    tv[2] = '{2, 8'hFF, 0, -1, 0};
    tv[3] = '{1, 8'h80, 1, 0, 1};
    tv[4] = '{1, 8'h8C, 1, 5, 2};
    tv[5] = '{0, 8'hC6, 2, 6, 3};
    tv[6] = '{3, 8'h18, 1, 4, 1};

    rst = 1'b1; req_valid = '0; req_data = '0; ctx_clr = '0; rd_ch = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hit_valid", hit_valid, 0);
    check("reset hit_ch", hit_ch, 0);
    check("reset hit_pos", hit_pos, 0);
    check("reset done_valid", done_valid, 0);
    check("reset done_ch", done_ch, 0);
    check("reset done_hits", done_hits, 0);
    check("reset busy", busy, 0);
    check("reset req_ready", req_ready, 0);
    for (int c = 0; c < NCH; c++) begin
      rd_ch = 2'(c); #1;
      check("reset rd_cnt", rd_cnt, 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_word(tv[i].ch, tv[i].d, -1, -1);
      check("tbl grant", gcyc, 0);
      check("tbl nhit", nhit, tv[i].nhit);
      check("tbl hit_pos", hpos, tv[i].pos);
      if (tv[i].nhit > 0) begin
        check("tbl hit_ch", hch, tv[i].ch);
        check("tbl hit cycle", hcyc, tv[i].pos + 2);
      end
      check("tbl done cycle", dcyc, 10);
      check("tbl done_hits", dhits, tv[i].nhit);
      check("tbl done_ch", dch, tv[i].ch);
      rd_ch = 2'(tv[i].ch); #1;
      check("tbl rd_cnt", rd_cnt, tv[i].cnt);
    end

    // Arbitration with all channels requesting continuously
    @(posedge clk); #1;
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    req_data = {NCH{8'hFF}};
    req_valid = '1;
    k = 0;
    for (int c = 0; c < 80 && k < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check("rr onehot", $countones(req_ready), 1);
        gch = -1;
        for (int j = 0; j < NCH; j++) if (req_ready[j]) gch = j;
        gseq[k] = gch; gt[k] = c; k++;
      end
    end
    req_valid = '0;
    check("rr grant count", k, 5);
    for (int i = 0; i < 5; i++) begin
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % NCH;
`endif
      if (i < k) begin
        check("rr order", gseq[i], exp_g);
        if (i > 0) check("rr spacing", gt[i] - gt[i-1], 10);
      end
    end
    repeat (12) @(posedge clk);

    // Counter saturation on ch3
    #1; rst = 1'b1; #2; rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      do_word(3, 8'h18, -1, -1);
      check("sat done_hits", dhits, 1);
      rd_ch = 2'd3; #1;
      if (n == 253) check("sat rd_cnt 254", rd_cnt, 254);
      if (n == 254) check("sat rd_cnt 255", rd_cnt, 255);
    end
    check("sat rd_cnt final", rd_cnt, 255);

    // Reset in the middle of a ch0 word
    do_word(0, 8'h18, -1, -1);
    check("pre-rst nhit", nhit, 1);
    do_word(0, 8'h18, -1, 4);
    #1;
    rd_ch = 2'd0; #1;
    check("rst busy", busy, 0);
    check("rst hit_valid", hit_valid, 0);
    check("rst done_valid", done_valid, 0);
    check("rst done_hits", done_hits, 0);
    check("rst req_ready", req_ready, 0);
    check("rst rd_cnt", rd_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done_valid) ndone++;
    end
    check("rst no done", ndone, 0);
    do_word(0, 8'hC0, -1, -1);
    check("post-rst grant", gcyc, 0);
    check("post-rst nhit", nhit, 0);
    check("post-rst done_hits", dhits, 0);

    // ctx_clr during an active ch0 word that hits
    do_word(0, 8'h18, -1, -1);
    rd_ch = 2'd0; #1;
    check("clr pre rd_cnt", rd_cnt, 1);
    do_word(0, 8'h18, 2, -1);
    check("clr nhit", nhit, 1);
    check("clr hit_pos", hpos, 4);
    check("clr done_hits", dhits, 1);
    rd_ch = 2'd0; #1;
    check("clr rd_cnt", rd_cnt, 0);
    do_word(0, 8'hC0, -1, -1);
    check("clr ctx S0 nhit", nhit, 0);
    rd_ch = 2'd0; #1;
    check("clr rd_cnt after", rd_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
